poly_note_player: RTL
=====================

Name: poly_note_player

Overview:
- Multi-channel successor to the single free-running scale generator.
- Plays note commands on CHANNELS independent square-wave voices; each command gives note index, octave and duration.
- A valid/ready command port is fed by the song sequencer. Per-channel speaker lines and a popcount mix feed the audio DAC/PWM stage.
- Adds features the old block lacks: commanded notes, timed durations, rests, per-channel stop, and polyphony.

Parameters:
CHANNELS, 4, number of independent voices (1..8)
DUR_W, 8, width of the duration field in ticks
TICK_DIV, 65536, clocks per duration tick (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted on an edge where valid&&ready
cmd_chan  in  max(1,clog2(CHANNELS))  target channel
cmd_note  in  4  0=A .. 11=G#; 12..15 = rest
cmd_octave  in  3  0 (lowest) .. 5 (highest); 6,7 clamp to 5
cmd_dur  in  DUR_W  length in ticks; 0 = no-op
stop  in  CHANNELS  per-channel immediate silence
busy  out  CHANNELS  channel playing (note or rest)
speaker  out  CHANNELS  per-channel square wave
mix  out  clog2(CHANNELS+1)  popcount of speaker (combinational from registered speaker)

Behaviour:
- One clock domain, synchronous active-high reset. All state clears on reset: busy=0, speaker=0, counters=0, prescaler=0. cmd_ready=0 while reset is high.
- Note divider table DIV[n] = 511,482,455,430,405,383,361,341,322,303,286,270 for n=0..11.
- Octave reload R = (256>>oct)-1 (255,127,63,31,15,7); oct 6,7 use 7.
- cmd_ready = !reset && (cmd_chan<CHANNELS) && !busy[cmd_chan]. Out-of-range channel: ready=0 forever; the sequencer must not issue it.
- Accept with cmd_dur!=0, on the accepting edge, for channel c:
  - note_cnt=DIV, oct_cnt=R, dur_cnt=cmd_dur, speaker=0, busy=1.
  - rest flag = (cmd_note>=12).
- Accept with cmd_dur==0: handshake completes, channel state unchanged.
- Tone engine per busy, non-rest channel, each edge:
  - note_cnt==0 → reload DIV, else decrement.
  - When note_cnt==0: oct_cnt==0 → reload R and toggle speaker; else decrement oct_cnt.
  - First toggle (speaker→1) occurs exactly (R+1)*(DIV+1) clocks after the accepting edge. Half-period is (R+1)*(DIV+1) thereafter.
- Rest channel: speaker held 0, duration still counts, busy=1.
- Prescaler: global free-running counter 0..TICK_DIV-1; tick asserts for one clock when it equals TICK_DIV-1.
- On tick, each busy channel decrements dur_cnt. The tick that takes dur_cnt to 0 also clears busy and forces speaker=0 on the same edge.
- Played length is in ((dur-1)*TICK_DIV, dur*TICK_DIV] clocks, because the prescaler is not restarted per command.
- A channel is re-acceptable the cycle after busy clears; no back-to-back accept on the same channel in the expiring cycle.
- stop[c]=1: on that edge busy[c]=0, speaker[c]=0, counters cleared.
  - stop has priority over tick expiry and over a simultaneous accept to c.
  - If cmd_ready was high, the command is still consumed and discarded.
- Channels are fully independent. A tick and an accept on different channels in one cycle both take effect.
- Reset mid-note: all channels silent and idle on the next cycle. The prescaler restarts at 0.

Test Plan:
- Reset → busy=0, speaker=0, mix=0; after deassert cmd_ready=1 for chan 0.
- TICK_DIV=16, chan0 note0 oct5 dur=255 → speaker0 rises exactly 4096 clks after accept, then toggles every 4096; busy0=1; cmd_ready low for chan0 and high for chan1.
- TICK_DIV=16, chan1 note11 oct0 dur=3 → first toggle at 256*271=69376 clk not reached. busy1 clears within 33..48 clks; speaker1 stays 0.
- Rest: chan2 note 13 dur=2, TICK_DIV=16 → busy2=1 for 17..32 clks, speaker2 always 0. dur=0 command → handshake completes, busy2 stays 0.
- Polyphony: chans0..3 note3 oct5 together, accepted on consecutive cycles → mix steps 0→1→2→3→4 at 8*431=3448 clks after each respective accept. stop=4'b0101 → speaker0/2 and busy0/2 clear next edge; mix=2.
- Conflicts: stop[1] with accept to idle chan1 → command consumed, busy1=0. Reset asserted while 3 channels play → all outputs 0 next cycle.

Source files
------------

// File: rtl/poly_note_player_if.sv
// Command port between the song sequencer (master) and poly_note_player (slave).
// One note/rest command per valid&&ready edge.
interface poly_note_player_if #(
    parameter int CHANNELS = 4,
    parameter int DUR_W    = 8
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CHAN_W-1:0] cmd_chan;
    logic [3:0]        cmd_note;
    logic [2:0]        cmd_octave;
    logic [DUR_W-1:0]  cmd_dur;

    modport master (
        output cmd_valid, cmd_chan, cmd_note, cmd_octave, cmd_dur,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_note, cmd_octave, cmd_dur,
        output cmd_ready
    );
endinterface

// File: rtl/poly_note_player.sv
// Polyphonic square-wave note player: CHANNELS independent voices, each playing a
// commanded note/octave (or rest) for a duration counted in prescaler ticks.
module poly_note_player #(
    parameter int CHANNELS = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 65536
) (
    input  logic                           clk,
    input  logic                           reset,
    poly_note_player_if.slave              cmd,
    input  logic [CHANNELS-1:0]            stop,
    output logic [CHANNELS-1:0]            busy,
    output logic [CHANNELS-1:0]            speaker,
    output logic [$clog2(CHANNELS+1)-1:0]  mix
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MIX_W  = $clog2(CHANNELS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    function automatic logic [8:0] note_div(input logic [3:0] n);
        case (n)
            4'd0:    return 9'd511;
            4'd1:    return 9'd482;
            4'd2:    return 9'd455;
            4'd3:    return 9'd430;
            4'd4:    return 9'd405;
            4'd5:    return 9'd383;
            4'd6:    return 9'd361;
            4'd7:    return 9'd341;
            4'd8:    return 9'd322;
            4'd9:    return 9'd303;
            4'd10:   return 9'd286;
            4'd11:   return 9'd270;
            default: return '0;
        endcase
    endfunction

    function automatic logic [7:0] oct_reload(input logic [2:0] o);
        case (o)
            3'd0:    return 8'd255;
            3'd1:    return 8'd127;
            3'd2:    return 8'd63;
            3'd3:    return 8'd31;
            3'd4:    return 8'd15;
            default: return 8'd7;
        endcase
    endfunction

    logic [PRE_W-1:0]  presc;
    logic              tick;
    logic              chan_ok;
    logic              sel_busy;
    logic              ready;
    logic              accept;
    logic [CHANNELS-1:0] load;
    logic [CHANNELS-1:0] rest;
    logic [8:0]        note_cnt [CHANNELS];
    logic [8:0]        div_q    [CHANNELS];
    logic [7:0]        oct_cnt  [CHANNELS];
    logic [7:0]        rld_q    [CHANNELS];
    logic [DUR_W-1:0]  dur_cnt  [CHANNELS];

    // Select busy of the addressed channel without indexing past CHANNELS.
    always_comb begin
        sel_busy = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (cmd.cmd_chan == CHAN_W'(c)) sel_busy = busy[c];
        end
    end

    assign chan_ok       = {1'b0, cmd.cmd_chan} < (CHAN_W + 1)'(CHANNELS);
    assign ready         = !reset && chan_ok && !sel_busy;
    assign cmd.cmd_ready = ready;
    assign accept        = cmd.cmd_valid && ready;
    assign tick          = (presc == PRE_LAST);

    always_comb begin
        load = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            load[c] = accept && (cmd.cmd_chan == CHAN_W'(c)) && (cmd.cmd_dur != '0);
        end
    end

    always_comb begin
        mix = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            mix = mix + MIX_W'(speaker[c]);
        end
    end

    // Global prescaler; never restarted per command, so played length varies by up to one tick.
    always_ff @(posedge clk) begin
        if (reset || tick) presc <= '0;
        else               presc <= presc + 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (reset || stop[c]) begin
                busy[c]     <= 1'b0;
                speaker[c]  <= 1'b0;
                rest[c]     <= 1'b0;
                note_cnt[c] <= '0;
                div_q[c]    <= '0;
                oct_cnt[c]  <= '0;
                rld_q[c]    <= '0;
                dur_cnt[c]  <= '0;
            end else if (load[c]) begin
                busy[c]     <= 1'b1;
                speaker[c]  <= 1'b0;
                rest[c]     <= (cmd.cmd_note >= 4'd12);
                note_cnt[c] <= note_div(cmd.cmd_note);
                div_q[c]    <= note_div(cmd.cmd_note);
                oct_cnt[c]  <= oct_reload(cmd.cmd_octave);
                rld_q[c]    <= oct_reload(cmd.cmd_octave);
                dur_cnt[c]  <= cmd.cmd_dur;
            end else if (busy[c]) begin
                if (tick && dur_cnt[c] == DUR_W'(1)) begin
                    busy[c]     <= 1'b0;
                    speaker[c]  <= 1'b0;
                    note_cnt[c] <= '0;
                    oct_cnt[c]  <= '0;
                    dur_cnt[c]  <= '0;
                end else begin
                    if (tick) dur_cnt[c] <= dur_cnt[c] - 1'b1;
                    // Octave counter advances once per full note-divider period.
                    if (!rest[c]) begin
                        if (note_cnt[c] == '0) begin
                            note_cnt[c] <= div_q[c];
                            if (oct_cnt[c] == '0) begin
                                oct_cnt[c] <= rld_q[c];
                                speaker[c] <= ~speaker[c];
                            end else begin
                                oct_cnt[c] <= oct_cnt[c] - 1'b1;
                            end
                        end else begin
                            note_cnt[c] <= note_cnt[c] - 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
